pwm_capture: RTL

Four-channel pulse-width capture block: the receive-side counterpart of the team's Wishbone PWM generator. It measures the high time and period of incoming RC-receiver/servo PWM signals in prescaled ticks, 1 µs by default. It sits on the same 16-bit Wishbone slave bus as the PWM output block, so the flight software can read stick inputs. Each channel flags new data and drops its valid bit when its signal disappears.

---
 rtl/pwm_capture_pkg.sv | 24 ++
 rtl/pwm_capture_if.sv | 22 ++
 rtl/pwm_capture_chan.sv | 143 ++++++++++++++
 rtl/pwm_capture.sv | 98 +++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared constants, FSM state type and saturating adder for the PWM capture block.
package pwm_capture_pkg;

   localparam int CNT_W = 16;

   localparam logic [4:0] ADR_WIDTH0  = 5'h00;
   localparam logic [4:0] ADR_PERIOD0 = 5'h08;
   localparam logic [4:0] ADR_STATUS  = 5'h10;
   localparam logic [4:0] ADR_CTRL    = 5'h12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// 16-bit Wishbone slave bus bundle used by the PWM capture block.
interface pwm_capture_if;

   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [6:0]  wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );

endinterface

// File: rtl/pwm_capture_chan.sv
// One capture channel: synchronizer, edge detect, IDLE/HIGH/LOW FSM and result registers.
module pwm_capture_chan
   import pwm_capture_pkg::*;
#(
   parameter logic [CNT_W-1:0] TIMEOUT = 16'd50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   input  logic             tick,
   input  logic             clear_new,
   output logic [CNT_W-1:0] width_o,
   output logic [CNT_W-1:0] period_o,
   output logic             valid_o,
   output logic             new_o
);

   state_e           state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic [1:0]       prim_q, prim_d;
   logic             prev_q, prev_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             new_q, new_d;

   logic             rise_s, fall_s, set_new_s, timeout_s;
   logic [CNT_W-1:0] edge_cnt_s, since_rise_s;

   // Next-state, counters and result registers; prim_q masks edges until the synchronizer holds real samples
   always_comb begin
      sync_d  = {sync_q[0], pwm_in};
      prim_d  = {prim_q[0], 1'b1};
      prev_d  = sync_q[1];
      rise_s  = prim_q[1] & sync_q[1] & ~prev_q;
      fall_s  = prim_q[1] & ~sync_q[1] & prev_q;
      armed_d = armed_q | (prim_q[1] & ~sync_q[1]);

      // The tick landing on an edge belongs to the interval that edge closes.
      edge_cnt_s   = sat_add(cnt_q, {{(CNT_W-1){1'b0}}, tick});
      since_rise_s = (state_q == HIGH) ? cnt_q : sat_add(high_q, cnt_q);
      timeout_s    = (since_rise_s >= TIMEOUT);

      state_d   = state_q;
      high_d    = high_q;
      width_d   = width_q;
      period_d  = period_q;
      valid_d   = valid_q;
      set_new_s = 1'b0;

      if (rise_s || fall_s) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (tick && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         IDLE: begin
            if (rise_s && armed_q) begin
               state_d = HIGH;
            end else begin
               state_d = IDLE;
            end
         end
         HIGH: begin
            if (fall_s) begin
               state_d = LOW;
               width_d = edge_cnt_s;
               high_d  = edge_cnt_s;
            end else if (timeout_s) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else begin
               state_d = HIGH;
            end
         end
         LOW: begin
            if (rise_s) begin
               state_d   = HIGH;
               period_d  = sat_add(high_q, edge_cnt_s);
               valid_d   = 1'b1;
               set_new_s = 1'b1;
            end else if (timeout_s) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else begin
               state_d = LOW;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (set_new_s) begin
         new_d = 1'b1;
      end else if (clear_new) begin
         new_d = 1'b0;
      end else begin
         new_d = new_q;
      end
   end

   // Channel state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sync_q   <= 2'b00;
         prim_q   <= 2'b00;
         prev_q   <= 1'b0;
         armed_q  <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         high_q   <= {CNT_W{1'b0}};
         width_q  <= {CNT_W{1'b0}};
         period_q <= {CNT_W{1'b0}};
         valid_q  <= 1'b0;
         new_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         prim_q   <= prim_d;
         prev_q   <= prev_d;
         armed_q  <= armed_d;
         cnt_q    <= cnt_d;
         high_q   <= high_d;
         width_q  <= width_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         new_q    <= new_d;
      end
   end

   assign width_o  = width_q;
   assign period_o = period_q;
   assign valid_o  = valid_q;
   assign new_o    = new_q;

endmodule

// File: rtl/pwm_capture.sv
// Four-channel PWM capture with shared tick prescaler and a 16-bit Wishbone register interface.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int               PRESCALE = 50,
   parameter logic [CNT_W-1:0] TIMEOUT  = 16'd50000
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n_i,
   pwm_capture_if.slave  wb,
   input  logic          pwm_in1,
   input  logic          pwm_in2,
   input  logic          pwm_in3,
   input  logic          pwm_in4
);

   logic [15:0]      pre_q, pre_d;
   logic             ack_q, ack_d;
   logic [15:0]      dat_q, dat_d;

   logic             tick_s, req_s;
   logic [3:0]       pwm_s, clear_new_s, valid_s, new_s;
   logic [15:0]      rd_s;
   logic [4:0]       adr_s;
   logic [CNT_W-1:0] width_s  [4];
   logic [CNT_W-1:0] period_s [4];
   logic             unused_s;

   assign pwm_s    = {pwm_in4, pwm_in3, pwm_in2, pwm_in1};
   assign adr_s    = wb.wb_adr_i[4:0];
   assign unused_s = ^{wb.wb_adr_i[6:5], wb.wb_dat_i[15:8], wb.wb_dat_i[3:0]};

   for (genvar i = 0; i < 4; i++) begin : g_chan
      pwm_capture_chan #(.TIMEOUT(TIMEOUT)) u_chan (
         .clk       (wb_clk_i),
         .rst_n     (wb_rst_n_i),
         .pwm_in    (pwm_s[i]),
         .tick      (tick_s),
         .clear_new (clear_new_s[i]),
         .width_o   (width_s[i]),
         .period_o  (period_s[i]),
         .valid_o   (valid_s[i]),
         .new_o     (new_s[i])
      );
   end

   // Prescaler, bus request decode, W1C strobes and read mux
   always_comb begin
      tick_s = (pre_q == 16'(PRESCALE - 1));
      pre_d  = tick_s ? 16'd0 : (pre_q + 16'd1);

      // Forcing a request to wait while ack is high makes every access take two clocks.
      req_s = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
      ack_d = req_s;

      if (req_s && wb.wb_we_i && (adr_s == ADR_CTRL)) begin
         clear_new_s = wb.wb_dat_i[7:4];
      end else begin
         clear_new_s = 4'b0000;
      end

      case (adr_s)
         ADR_WIDTH0:          rd_s = width_s[0];
         ADR_WIDTH0 + 5'd2:   rd_s = width_s[1];
         ADR_WIDTH0 + 5'd4:   rd_s = width_s[2];
         ADR_WIDTH0 + 5'd6:   rd_s = width_s[3];
         ADR_PERIOD0:         rd_s = period_s[0];
         ADR_PERIOD0 + 5'd2:  rd_s = period_s[1];
         ADR_PERIOD0 + 5'd4:  rd_s = period_s[2];
         ADR_PERIOD0 + 5'd6:  rd_s = period_s[3];
         ADR_STATUS:          rd_s = {8'h00, new_s, valid_s};
         default:             rd_s = 16'h0000;
      endcase

      if (req_s && !wb.wb_we_i) begin
         dat_d = rd_s;
      end else begin
         dat_d = 16'h0000;
      end
   end

   // Prescaler and bus response registers
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         pre_q <= 16'd0;
         ack_q <= 1'b0;
         dat_q <= 16'h0000;
      end else begin
         pre_q <= pre_d;
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;

endmodule
